// File: rtl/amy_gpio_port.sv
// AMY MCU GPIO port: registered pad outputs, input synchroniser, optional debounce,
// and edge-detect interrupts with sticky status. One amy_gpio_pin instance per pin.

module amy_gpio_pin #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_LIMIT    = 4
) (
   input  logic clk_in,
   input  logic rst,
   input  logic pad,
   input  logic db_en,
   input  logic int_en,
   input  logic int_rise,
   input  logic int_fall,
   input  logic int_clr,
   output logic stable,
   output logic status
);
   localparam int CW = $clog2(DB_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_LIMIT - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   sync_q, prev, rise, fall, set;

   assign sync_q = sync[SYNC_STAGES-1];

   always_ff @(posedge clk_in) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], pad};
   end

   // cnt tracks consecutive cycles where sync_q disagrees with the accepted level
   always_ff @(posedge clk_in) begin
      if (rst) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (!db_en) begin
         stable <= sync_q;
         cnt    <= '0;
      end else if (sync_q == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync_q;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign rise = stable & ~prev;
   assign fall = ~stable & prev;
   assign set  = int_en & ((int_rise & rise) | (int_fall & fall));

   // A set arriving on the same edge as a clear keeps the flag
   always_ff @(posedge clk_in) begin
      if (rst) begin
         prev   <= 1'b0;
         status <= 1'b0;
      end else begin
         prev   <= stable;
         status <= set | (status & ~int_clr);
      end
   end
endmodule

module amy_gpio_port #(
   parameter int NPIN        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_LIMIT    = 4
) (
   input  logic            clk_in,
   input  logic            rst,
   input  logic [NPIN-1:0] gpio_out,
   input  logic [NPIN-1:0] gpio_oe,
   input  logic [NPIN-1:0] db_en,
   input  logic [NPIN-1:0] int_en,
   input  logic [NPIN-1:0] int_rise,
   input  logic [NPIN-1:0] int_fall,
   input  logic [NPIN-1:0] int_clr,
   output logic [NPIN-1:0] gpio_in,
   output logic [NPIN-1:0] int_status,
   output logic            irq,
   input  logic [NPIN-1:0] pad_i,
   output logic [NPIN-1:0] pad_o,
   output logic [NPIN-1:0] pad_oe
);
   always_ff @(posedge clk_in) begin
      if (rst) begin
         pad_o  <= '0;
         pad_oe <= '0;
      end else begin
         pad_o  <= gpio_out;
         pad_oe <= gpio_oe;
      end
   end

   for (genvar p = 0; p < NPIN; p++) begin : g_pin
      amy_gpio_pin #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_LIMIT    (DB_LIMIT)
      ) u_pin (
         .clk_in   (clk_in),
         .rst      (rst),
         .pad      (pad_i[p]),
         .db_en    (db_en[p]),
         .int_en   (int_en[p]),
         .int_rise (int_rise[p]),
         .int_fall (int_fall[p]),
         .int_clr  (int_clr[p]),
         .stable   (gpio_in[p]),
         .status   (int_status[p])
      );
   end

   assign irq = |int_status;
endmodule

// File: tb/tb_amy_gpio_port.sv
// Bench for amy_gpio_port: directed test-plan steps followed by a randomized phase,
// all cycles checked against a cycle-level behavioural reference model.

module tb_amy_gpio_port;
   localparam int NPIN = 8;
   localparam int SYNC = 2;
   localparam int DB   = 4;

   logic            clk_in = 1'b0;
   logic            rst;
   logic [NPIN-1:0] gpio_out, gpio_oe, db_en, int_en, int_rise, int_fall, int_clr, pad_i;
   logic [NPIN-1:0] gpio_in, int_status, pad_o, pad_oe;
   logic            irq;

   int tests = 0;
   int fails = 0;

   amy_gpio_port #(.NPIN(NPIN), .SYNC_STAGES(SYNC), .DB_LIMIT(DB)) dut (
      .clk_in(clk_in), .rst(rst), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
      .db_en(db_en), .int_en(int_en), .int_rise(int_rise), .int_fall(int_fall),
      .int_clr(int_clr), .gpio_in(gpio_in), .int_status(int_status), .irq(irq),
      .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: pad samples delayed SYNC edges, then a per-pin run of
   // differing samples that must reach the acceptance length before the level moves.
   logic [NPIN-1:0] m_hist [SYNC];
   logic [NPIN-1:0] m_level, m_last, m_status, m_pado, m_padoe;
   int              m_run [NPIN];

   task automatic model_edge();
      logic [NPIN-1:0] seen, new_level, ev;
      if (rst) begin
         for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
         for (int p = 0; p < NPIN; p++) m_run[p] = 0;
         m_level = '0; m_last = '0; m_status = '0; m_pado = '0; m_padoe = '0;
         return;
      end
      seen      = m_hist[SYNC-1];
      new_level = m_level;
      for (int p = 0; p < NPIN; p++) begin
         int need;
         need = db_en[p] ? DB : 1;
         m_run[p] = (seen[p] != m_level[p]) ? m_run[p] + 1 : 0;
         if (m_run[p] >= need) begin
            new_level[p] = seen[p];
            m_run[p] = 0;
         end
         if (!db_en[p]) m_run[p] = 0;
      end
      ev = int_en & ((int_rise & m_level & ~m_last) | (int_fall & ~m_level & m_last));
      m_status = ev | (m_status & ~int_clr);
      m_last   = m_level;
      m_level  = new_level;
      for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pad_i;
      m_pado    = gpio_out;
      m_padoe   = gpio_oe;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      model_edge();
      #1;
      chk("m_gpio_in", 32'(gpio_in), 32'(m_level));
      chk("m_int_status", 32'(int_status), 32'(m_status));
      chk("m_irq", 32'(irq), 32'(|m_status));
      chk("m_pad_o", 32'(pad_o), 32'(m_pado));
      chk("m_pad_oe", 32'(pad_oe), 32'(m_padoe));
   endtask

   initial begin
      rst = 1'b1; pad_i = 8'hFF; gpio_oe = 8'hFF; gpio_out = '0;
      db_en = '0; int_en = '0; int_rise = '0; int_fall = '0; int_clr = '0;

      // Reset held three edges
      repeat (3) step();
      chk("rst_pad_oe", 32'(pad_oe), 0);
      chk("rst_pad_o", 32'(pad_o), 0);
      chk("rst_gpio_in", 32'(gpio_in), 0);
      chk("rst_status", 32'(int_status), 0);
      chk("rst_irq", 32'(irq), 0);

      // First high level after reset is a rising edge
      rst = 1'b0; int_en = 8'hFF; int_rise = 8'hFF;
      repeat (2) step();
      chk("rel_gpio_in_e2", 32'(gpio_in), 0);
      step();
      chk("rel_gpio_in_e3", 32'(gpio_in), 32'hFF);
      chk("rel_status_e3", 32'(int_status), 0);
      step();
      chk("rel_status_e4", 32'(int_status), 32'hFF);
      chk("rel_irq_e4", 32'(irq), 1);
      int_clr = 8'hFF; step(); int_clr = '0;
      chk("clr_all", 32'(int_status), 0);

      // Falls with int_fall=0 leave status alone
      pad_i = '0;
      repeat (5) step();
      chk("fall_nofall_gpio", 32'(gpio_in), 0);
      chk("fall_nofall_status", 32'(int_status), 0);

      // Debounce reject: 3-cycle pulse on pin 1
      db_en = 8'h02; pad_i = 8'h02;
      repeat (3) step();
      pad_i = '0;
      repeat (8) step();
      chk("db_reject_gpio", 32'(gpio_in), 0);
      chk("db_reject_status", 32'(int_status), 0);

      // Debounce accept: level lands after edge 6
      pad_i = 8'h02;
      repeat (5) step();
      chk("db_accept_e5", 32'(gpio_in[1]), 0);
      step();
      chk("db_accept_e6", 32'(gpio_in[1]), 1);
      step();
      chk("db_accept_irq", 32'(int_status), 32'h02);
      int_clr = 8'hFF; step(); int_clr = '0;

      // Clear/set collision on pin 2
      int_fall = 8'h04; pad_i = 8'h06;
      repeat (4) step();
      chk("col_rise_set", 32'(int_status[2]), 1);
      pad_i = 8'h02;
      repeat (3) step();
      int_clr = 8'h04; step(); int_clr = '0;
      chk("col_set_wins", 32'(int_status[2]), 1);
      step();
      chk("col_sticky", 32'(int_status[2]), 1);
      int_clr = 8'hFF; step(); int_clr = '0;
      chk("col_cleared", 32'(int_status), 0);
      chk("col_irq_low", 32'(irq), 0);

      // Output path: one edge of latency, old values hold until then
      gpio_oe = 8'hA5; gpio_out = 8'h3C;
      #1;
      chk("out_hold_oe", 32'(pad_oe), 32'hFF);
      chk("out_hold_o", 32'(pad_o), 0);
      step();
      chk("out_new_oe", 32'(pad_oe), 32'hA5);
      chk("out_new_o", 32'(pad_o), 32'h3C);

      // Reset in the middle of a debounce count on pin 3
      db_en = 8'h0A; pad_i = 8'h0A;
      repeat (4) step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_gpio", 32'(gpio_in), 0);
      repeat (5) step();
      chk("mid_rst_e5", 32'(gpio_in), 0);
      step();
      chk("mid_rst_e6", 32'(gpio_in), 32'h0A);

      // Randomized phase
      for (int c = 0; c < 600; c++) begin
         logic [NPIN-1:0] flip;
         flip = '0;
         for (int p = 0; p < NPIN; p++) if ($urandom_range(5) == 0) flip[p] = 1'b1;
         pad_i    = pad_i ^ flip;
         gpio_out = NPIN'($urandom);
         gpio_oe  = NPIN'($urandom);
         if ($urandom_range(19) == 0) db_en = NPIN'($urandom);
         if (c % 40 == 0) begin
            int_en = NPIN'($urandom); int_rise = NPIN'($urandom); int_fall = NPIN'($urandom);
         end
         int_clr = ($urandom_range(7) == 0) ? NPIN'($urandom) : '0;
         rst     = ($urandom_range(149) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/amy_gpio_port.md
# amy_gpio_port

Parametrised GPIO port for the AMY MCU family. It sits between the core's GPIO register block and the chip-level tristate pads, and replaces the fixed 8-pin pass-through wiring. It provides:
- NPIN-wide registered output and output-enable paths to the pads;
- a multi-stage input synchroniser;
- optional per-pin debounce;
- per-pin edge-detect interrupts with sticky status and a combined IRQ.

Pad tristate cells stay in the IO top; this block only produces and consumes pad-side `_i/_o/_oe` signals.

## Interface
Parameters:
- NPIN, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DB_LIMIT, 4, consecutive stable cycles needed to accept a debounced change (>=1).

Ports:
- clk_in  input  1  single clock; every flop is clocked on the rising edge.
- rst  input  1  synchronous, active-high reset; one clock, one synchronous active-high reset.
- gpio_out  input  NPIN  core output data.
- gpio_oe  input  NPIN  core output enable, 1 = drive.
- db_en  input  NPIN  per-pin debounce enable.
- int_en  input  NPIN  per-pin interrupt enable.
- int_rise  input  NPIN  per-pin rising-edge interrupt select.
- int_fall  input  NPIN  per-pin falling-edge interrupt select.
- int_clr  input  NPIN  per-pin one-cycle status-clear pulse.
- gpio_in  output  NPIN  filtered input value to the core.
- int_status  output  NPIN  sticky per-pin interrupt flags.
- irq  output  1  OR of int_status.
- pad_i  input  NPIN  raw pad input (asynchronous).
- pad_o  output  NPIN  registered pad output data.
- pad_oe  output  NPIN  registered pad output enable.

## Operation
- Output path: pad_o <= gpio_out and pad_oe <= gpio_oe on every edge. There is no other logic in this path.
- Synchroniser: a SYNC_STAGES flop chain per pin. sync_q is the last stage.
- Debounce, per pin, using a counter cnt of width $clog2(DB_LIMIT+1):
  - db_en=0: stable <= sync_q every edge; cnt held at 0.
  - db_en=1, sync_q == stable: cnt <= 0.
  - db_en=1, sync_q != stable, cnt == DB_LIMIT-1: stable <= sync_q, cnt <= 0.
  - db_en=1, sync_q != stable, otherwise: cnt <= cnt+1.
  - Any single cycle of agreement restarts the count.
  - Toggling db_en mid-count: 1->0 clears cnt; 0->1 starts counting from 0.
- gpio_in = stable, driven directly from the register.
- Edge detect:
  - prev <= stable every edge.
  - rise = stable & ~prev; fall = ~stable & prev.
- Interrupt status, per pin:
  - set = int_en & ((int_rise & rise) | (int_fall & fall)).
  - int_status <= set | (int_status & ~int_clr).
  - Set wins over a simultaneous clear.
  - Clearing int_en does not clear existing status.
- irq = |int_status, a combinational OR of the status flops.
- Reset (rst=1 at an edge) clears sync chains, stable, prev, cnt, int_status, pad_o and pad_oe, at any point including mid-debounce.
- Consequence of reset: the first pad value of 1 seen after reset registers as a rising edge.

## Timing
- Reset values: gpio_in=0, int_status=0, irq=0, pad_o=0, pad_oe=0 (all pins input).
- Output latency: gpio_out/gpio_oe -> pad_o/pad_oe is 1 edge.
- Input latency: a pad level that is steady from edge 1 onward appears on gpio_in after edge SYNC_STAGES+DB_LIMIT.
  - With db_en=0 this is edge SYNC_STAGES+1, i.e. the effective DB_LIMIT is 1.
- int_status sets 1 edge after gpio_in changes; irq rises in the same cycle.
- Pulses shorter than DB_LIMIT cycles at sync_q (db_en=1) are fully rejected and produce no edge.
- int_clr takes effect at the next edge; int_status reads 0 in the following cycle unless a new set arrives at that edge.

## Test plan
All scenarios use NPIN=8, SYNC_STAGES=2, DB_LIMIT=4.
- Reset: pad_i=8'hFF, gpio_oe=8'hFF, rst held 3 edges -> pad_oe=0, pad_o=0, gpio_in=0, int_status=0, irq=0. After release, with int_en=8'hFF and int_rise=8'hFF, gpio_in=8'hFF at edge 3 and int_status=8'hFF, irq=1 at edge 4.
- No debounce: db_en=0, int_en[0]=int_rise[0]=1, pad_i[0] 0->1 before edge 1 -> gpio_in[0]=1 after edge 3, int_status[0]=1 and irq=1 after edge 4. A fall with int_fall[0]=0 leaves int_status unchanged.
- Debounce, reject: db_en[1]=1, pad_i[1] high for exactly 3 cycles -> gpio_in[1] stays 0, no interrupt.
- Debounce, accept: pad_i[1] high for 4+ cycles -> gpio_in[1]=1 after edge 6.
- Clear/set collision: int_status[2]=1, int_clr[2] pulsed on the same edge a new falling edge sets it (int_fall[2]=1) -> int_status[2] remains 1. A later lone int_clr[2] -> 0, irq=0.
- Output path: gpio_oe=8'hA5, gpio_out=8'h3C applied before edge n -> pad_oe=8'hA5, pad_o=8'h3C after edge n. The previous values hold until then.
- Reset mid-operation: rst asserted during a debounce count at cnt=2 -> cnt=0, gpio_in=0. After release the count restarts, so a full 4 more matching cycles are needed.
